// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states,
// owner encoding and the latency counter width helper.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPT,
      RESP
   } state_t;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_LDR  = 1'b1;

   // Width of the WAIT-state counter; at least one bit so MEM_LAT = 1 still elaborates.
   function automatic int lat_cnt_w(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port instruction/data memory between the core
// (port A) and the program loader / debug port (port B). One transaction is in
// flight at a time; all memory-side and requester-side outputs are registered.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 1,
   parameter int LDR_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_ready,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_lat_range
      $error("mem_port_arbiter: MEM_LAT must be in 1..8");
   end

   localparam int               CNT_W    = lat_cnt_w(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

   state_t           state;
   logic             last_grant;
   logic             lat_we;
   logic [CNT_W-1:0] cnt;
   logic             pick;

   // Owner selection for the IDLE cycle: round-robin on a tie, or loader first when LDR_PRIO is set.
   always_comb begin
      pick = OWN_CORE;
      if (core_req && ldr_req) begin
         pick = (LDR_PRIO != 0) ? OWN_LDR : ~last_grant;
      end else if (ldr_req) begin
         pick = OWN_LDR;
      end
   end

   // Transaction FSM: grant, issue, wait out the memory latency, capture read data, pulse ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= OWN_LDR;
         lat_we     <= 1'b0;
         cnt        <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_rdata <= '0;
         ldr_rdata  <= '0;
         core_ready <= 1'b0;
         ldr_ready  <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= OWN_CORE;
      end else begin
         core_ready <= 1'b0;
         ldr_ready  <= 1'b0;
         case (state)
            IDLE: begin
               if (core_req || ldr_req) begin
                  state      <= ISSUE;
                  busy       <= 1'b1;
                  grant_id   <= pick;
                  last_grant <= pick;
                  mem_en     <= 1'b1;
                  if (pick == OWN_LDR) begin
                     lat_we    <= ldr_we;
                     mem_we    <= ldr_we;
                     mem_addr  <= ldr_addr;
                     mem_wdata <= ldr_wdata;
                  end else begin
                     lat_we    <= core_we;
                     mem_we    <= core_we;
                     mem_addr  <= core_addr;
                     mem_wdata <= core_wdata;
                  end
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (MEM_LAT == 1) begin
                  state <= CAPT;
               end else begin
                  cnt   <= CNT_INIT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= CAPT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            CAPT: begin
               if (!lat_we) begin
                  if (grant_id == OWN_LDR) begin
                     ldr_rdata <= mem_rdata;
                  end else begin
                     core_rdata <= mem_rdata;
                  end
               end
               if (grant_id == OWN_LDR) begin
                  ldr_ready <= 1'b1;
               end else begin
                  core_ready <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. Four instances with different
// MEM_LAT / LDR_PRIO settings run side by side in lockstep; a transaction-level
// model schedules the expected issue, capture and ready cycles of each grant.
module tb_mem_port_arbiter;

   localparam int N      = 4;
   localparam int CYCLES = 2000;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 1;
         1:       return 3;
         2:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int prio_of(input int i);
      return (i >= 2) ? 1 : 0;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset      [N];
   logic        core_req   [N];
   logic        core_we    [N];
   logic [31:0] core_addr  [N];
   logic [31:0] core_wdata [N];
   logic [31:0] core_rdata [N];
   logic        core_ready [N];
   logic        ldr_req    [N];
   logic        ldr_we     [N];
   logic [31:0] ldr_addr   [N];
   logic [31:0] ldr_wdata  [N];
   logic [31:0] ldr_rdata  [N];
   logic        ldr_ready  [N];
   logic        mem_en     [N];
   logic        mem_we     [N];
   logic [31:0] mem_addr   [N];
   logic [31:0] mem_wdata  [N];
   logic [31:0] mem_rdata  [N];
   logic        busy       [N];
   logic        grant_id   [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W  (32),
         .DATA_W  (32),
         .MEM_LAT (lat_of(gi)),
         .LDR_PRIO(prio_of(gi))
      ) u_dut (
         .clk       (clk),
         .reset     (reset[gi]),
         .core_req  (core_req[gi]),
         .core_we   (core_we[gi]),
         .core_addr (core_addr[gi]),
         .core_wdata(core_wdata[gi]),
         .core_rdata(core_rdata[gi]),
         .core_ready(core_ready[gi]),
         .ldr_req   (ldr_req[gi]),
         .ldr_we    (ldr_we[gi]),
         .ldr_addr  (ldr_addr[gi]),
         .ldr_wdata (ldr_wdata[gi]),
         .ldr_rdata (ldr_rdata[gi]),
         .ldr_ready (ldr_ready[gi]),
         .mem_en    (mem_en[gi]),
         .mem_we    (mem_we[gi]),
         .mem_addr  (mem_addr[gi]),
         .mem_wdata (mem_wdata[gi]),
         .mem_rdata (mem_rdata[gi]),
         .busy      (busy[gi]),
         .grant_id  (grant_id[gi])
      );
   end

   // Reference model: one scheduled transaction per instance plus a word memory.
   int          idle_at [N];
   int          iss     [N];
   int          cap     [N];
   int          rdy     [N];
   bit          tv      [N];
   bit          own     [N];
   bit          twe     [N];
   bit          last    [N];
   bit          rst_new [N];
   logic [31:0] taddr   [N];
   logic [31:0] twdata  [N];
   logic [31:0] trval   [N];
   logic [31:0] erd_c   [N];
   logic [31:0] erd_l   [N];
   logic [31:0] mem     [N][16];

   int n_cmp;
   int n_bad;
   int cur_k;

   task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, inst, cur_k, got, exp);
      end
   endtask

   task automatic model_reset(input int i, input int k);
      tv[i]      = 1'b0;
      last[i]    = 1'b1;
      idle_at[i] = k;
      erd_c[i]   = '0;
      erd_l[i]   = '0;
   endtask

   task automatic chk_zero(input int i);
      chk("rst_mem_en",     i, {31'b0, mem_en[i]},     32'd0);
      chk("rst_mem_we",     i, {31'b0, mem_we[i]},     32'd0);
      chk("rst_mem_addr",   i, mem_addr[i],            32'd0);
      chk("rst_mem_wdata",  i, mem_wdata[i],           32'd0);
      chk("rst_busy",       i, {31'b0, busy[i]},       32'd0);
      chk("rst_grant_id",   i, {31'b0, grant_id[i]},   32'd0);
      chk("rst_core_ready", i, {31'b0, core_ready[i]}, 32'd0);
      chk("rst_ldr_ready",  i, {31'b0, ldr_ready[i]},  32'd0);
      chk("rst_core_rdata", i, core_rdata[i],          32'd0);
      chk("rst_ldr_rdata",  i, ldr_rdata[i],           32'd0);
   endtask

   task automatic check_cycle(input int i, input int k);
      logic e_en, e_busy, e_gnt, e_crdy, e_lrdy;
      e_en   = tv[i] && (k == iss[i]);
      e_busy = tv[i] && (k < idle_at[i]);
      e_gnt  = tv[i] ? own[i] : 1'b0;
      e_crdy = tv[i] && (k == rdy[i]) && !own[i];
      e_lrdy = tv[i] && (k == rdy[i]) && own[i];
      if (tv[i] && (k == rdy[i]) && !twe[i]) begin
         if (own[i]) erd_l[i] = trval[i];
         else        erd_c[i] = trval[i];
      end
      chk("mem_en",     i, {31'b0, mem_en[i]},     {31'b0, e_en});
      chk("mem_we",     i, {31'b0, mem_we[i]},     {31'b0, e_en && twe[i]});
      chk("busy",       i, {31'b0, busy[i]},       {31'b0, e_busy});
      chk("grant_id",   i, {31'b0, grant_id[i]},   {31'b0, e_gnt});
      chk("core_ready", i, {31'b0, core_ready[i]}, {31'b0, e_crdy});
      chk("ldr_ready",  i, {31'b0, ldr_ready[i]},  {31'b0, e_lrdy});
      chk("core_rdata", i, core_rdata[i],          erd_c[i]);
      chk("ldr_rdata",  i, ldr_rdata[i],           erd_l[i]);
      if (e_en) begin
         chk("mem_addr",  i, mem_addr[i],  taddr[i]);
         chk("mem_wdata", i, mem_wdata[i], twdata[i]);
      end
      if (!tv[i]) begin
         chk("idle_mem_addr", i, mem_addr[i], 32'd0);
      end
   endtask

   // Drive the requesters for cycle k and let the model arbitrate if the port is idle.
   task automatic step(input int i, input int k);
      logic cr, lr, o;
      if (k < 300) begin
         cr = 1'b1;
         lr = (k < 200);
      end else begin
         cr = ($urandom_range(0, 9) < 6);
         lr = ($urandom_range(0, 9) < 6);
      end
      core_req[i]   = cr;
      core_we[i]    = 1'($urandom_range(0, 1));
      core_addr[i]  = $urandom;
      core_wdata[i] = $urandom;
      ldr_req[i]    = lr;
      ldr_we[i]     = 1'($urandom_range(0, 1));
      ldr_addr[i]   = $urandom;
      ldr_wdata[i]  = $urandom;
      if (k >= idle_at[i] && (cr || lr)) begin
         if (cr && lr) o = (prio_of(i) != 0) ? 1'b1 : !last[i];
         else          o = lr;
         last[i]    = o;
         tv[i]      = 1'b1;
         own[i]     = o;
         twe[i]     = o ? ldr_we[i]    : core_we[i];
         taddr[i]   = o ? ldr_addr[i]  : core_addr[i];
         twdata[i]  = o ? ldr_wdata[i] : core_wdata[i];
         iss[i]     = k + 1;
         cap[i]     = k + 1 + lat_of(i);
         rdy[i]     = k + 2 + lat_of(i);
         idle_at[i] = k + 3 + lat_of(i);
         if (twe[i]) mem[i][taddr[i][3:0]] = twdata[i];
         else        trval[i] = mem[i][taddr[i][3:0]];
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cur_k = -1;
      for (int i = 0; i < N; i++) begin
         reset[i]      = 1'b1;
         rst_new[i]    = 1'b0;
         core_req[i]   = 1'b0;
         core_we[i]    = 1'b0;
         core_addr[i]  = '0;
         core_wdata[i] = '0;
         ldr_req[i]    = 1'b0;
         ldr_we[i]     = 1'b0;
         ldr_addr[i]   = '0;
         ldr_wdata[i]  = '0;
         mem_rdata[i]  = '0;
         for (int w = 0; w < 16; w++) mem[i][w] = $urandom;
         model_reset(i, 0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) chk_zero(i);

      for (int k = 0; k < CYCLES; k++) begin
         cur_k = k;
         for (int i = 0; i < N; i++) begin
            check_cycle(i, k);
            if (reset[i]) begin
               reset[i] = 1'b0;
               step(i, k);
            end else if (k > 20 && $urandom_range(0, 149) == 0) begin
               reset[i]   = 1'b1;
               rst_new[i] = 1'b1;
               model_reset(i, k + 1);
            end else begin
               step(i, k);
            end
            mem_rdata[i] = (tv[i] && !twe[i] && k == cap[i]) ? trval[i] : $urandom;
         end
         #1;
         for (int i = 0; i < N; i++) begin
            if (rst_new[i]) begin
               chk_zero(i);
               rst_new[i] = 1'b0;
            end
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle core between two requesters: the core (port A: fetch, load, store) and the program loader/debug port (port B).
- Grants one transaction at a time and registers all memory-side outputs.
- Tracks a fixed memory read latency and returns a one-cycle ready pulse with registered read data to the owner.
- The core controller holds its current state while its request is pending and core_ready is low.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..8; any other value is an elaboration error.
- LDR_PRIO, 0, 0 = round-robin between ports; 1 = loader has fixed priority.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core transaction request, held until core_ready
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_rdata  out  DATA_W  registered read data for the core
- core_ready  out  1  one-cycle completion pulse to the core
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write enable
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_rdata  out  DATA_W  registered read data for the loader
- ldr_ready  out  1  one-cycle completion pulse to the loader
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in every state except IDLE
- grant_id  out  1  0 = core, 1 = loader; current or last owner

Behaviour:
- Reset (asynchronous): all outputs are 0. State = IDLE. last_grant = loader, so the core wins the first tie. An in-flight access is dropped and no ready pulse is issued.

State machine:
- IDLE: sample requests.
  - No request: stay in IDLE.
  - Otherwise pick an owner, latch its we/addr/wdata, set grant_id, go to ISSUE.
- ISSUE (1 cycle): mem_en = 1, mem_we = latched we, mem_addr and mem_wdata from the latched values.
  - MEM_LAT = 1: go to CAPT.
  - Otherwise go to WAIT.
- WAIT: counter counts MEM_LAT-1 cycles, then go to CAPT. mem_en = 0 and mem_we = 0.
- CAPT (1 cycle): mem_rdata is valid this cycle. On a read, it is loaded into the owner's rdata register at the closing edge. Go to RESP.
- RESP (1 cycle): owner's ready = 1, then go to IDLE. No arbitration happens in this cycle.

Timing:
- Request seen in IDLE at cycle t: mem_en at t+1, mem_rdata sampled at cycle t+1+MEM_LAT, ready at t+2+MEM_LAT.
- Minimum spacing between issues is MEM_LAT+3 cycles.

Arbitration:
- LDR_PRIO = 0: single request is granted directly. On a tie, grant the port that is not last_grant, then update last_grant.
- LDR_PRIO = 1: the loader wins every tie, so the core can starve while ldr_req is held.

Handshake rules:
- Address, data and we are captured only at grant; changes after grant are ignored.
- Dropping req after grant does not abort the transaction; ready is still pulsed.
- A request still high in the IDLE cycle after RESP is a new transaction.
- Writes complete the same way, but rdata is left unchanged.
- Each rdata holds its value until that port's next read completes.
- The non-owner's ready stays 0 throughout.
- mem_we is never high without mem_en.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE, ISSUE, WAIT, CAPT, RESP;
  - owner constants OWN_CORE = 0, OWN_LDR = 1;
  - latency counter width, derived as clog2 of MEM_LAT.
- Single module; no sub-module is needed.

Test Plan:
1. Core read, MEM_LAT = 1: core_req at cycle 0 to addr 0x10, memory returns 0xDEADBEEF. Expect mem_en only at cycle 1 with mem_addr 0x10, core_ready only at cycle 3, core_rdata = 0xDEADBEEF.
2. Loader write to 0x40 with data 0x12345678. Expect mem_en and mem_we high only at cycle 1 with mem_wdata 0x12345678, ldr_ready at cycle 3, ldr_rdata unchanged.
3. Both requests high from cycle 0, LDR_PRIO = 0. Expect the core granted first with ready at cycle 3; loader issued at cycle 5 with ldr_ready at cycle 7; grant_id sequence 0 then 1; a third tie goes to the core.
4. LDR_PRIO = 1, both requests held high. Expect every grant to go to the loader; core_ready never asserts until ldr_req drops, then the core is served within MEM_LAT+3 cycles.
5. MEM_LAT = 3, core read at cycle 0. Expect mem_en at cycle 1, mem_rdata sampled at cycle 4, core_ready at cycle 5; core_addr changed in cycle 2 has no effect.
6. reset asserted in WAIT (MEM_LAT = 3, cycle 2). Expect all outputs 0 immediately with no ready pulse. After release with core_req still high, a fresh grant occurs and mem_en is seen 1 cycle after the first IDLE.
